psg_voices: RTL

- Programmable sound source: two square-wave tone voices plus one LFSR noise voice, mixed and saturated to a signed 16-bit PCM sample.
- Sits directly upstream of the i2s serializer, on the same i2s bit clock.
- Advances one sample step per sample_req pulse from i2s (one per frame) and presents the new sample on sample, with sample_valid.
- Replaces the single-voice sound_gen where richer audio is needed.

---
 rtl/psg_voices.sv | 121 ++++++++++++
 1 files changed

// File: rtl/psg_voices.sv
// Two square-wave tone voices plus one LFSR noise voice.
// The voices are mixed and saturated to a signed 16-bit sample, one step per sample_req.
module psg_voices #(
  parameter int          AMP_SHIFT  = 11,
  parameter logic [14:0] NOISE_SEED = 15'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_req,
  input  logic [11:0] tone0_period,
  input  logic [3:0]  tone0_vol,
  input  logic [11:0] tone1_period,
  input  logic [3:0]  tone1_vol,
  input  logic [3:0]  noise_rate,
  input  logic [3:0]  noise_vol,
  output logic [15:0] sample,
  output logic        sample_valid
);

  logic        pend;
  logic        step;
  logic [11:0] cnt0;
  logic [11:0] cnt1;
  logic        ph0;
  logic        ph1;
  logic        on0;
  logic        on1;
  logic [7:0]  ncnt;
  logic [14:0] lfsr;
  logic        non;

  logic signed [18:0] lv0;
  logic signed [18:0] lv1;
  logic signed [18:0] lvn;
  logic signed [18:0] sum;
  logic [15:0]        sat;

  // A request is ignored while the previous one is still being mixed
  assign step = sample_req & ~pend;

  function automatic logic signed [18:0] level(
    input logic [3:0] vol,
    input logic       on,
    input logic       pos
  );
    logic signed [18:0] amp;
    amp = signed'(19'(vol) << AMP_SHIFT);
    if (!on || vol == 4'd0) return '0;
    return pos ? amp : -amp;
  endfunction

  always_comb begin
    lv0 = level(tone0_vol, on0, ph0);
    lv1 = level(tone1_vol, on1, ph1);
    lvn = level(noise_vol, non, lfsr[0]);
    sum = lv0 + lv1 + lvn;
    sat = sum[15:0];
    if (sum > 19'sd32767)
      sat = 16'h7FFF;
    else if (sum < -19'sd32768)
      sat = 16'h8000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend         <= 1'b0;
      cnt0         <= '0;
      cnt1         <= '0;
      ph0          <= 1'b0;
      ph1          <= 1'b0;
      on0          <= 1'b0;
      on1          <= 1'b0;
      ncnt         <= '0;
      lfsr         <= NOISE_SEED;
      non          <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      pend         <= step;
      sample_valid <= 1'b0;
      if (step) begin
        on0 <= tone0_period != 12'd0;
        if (tone0_period == 12'd0) begin
          cnt0 <= '0;
          ph0  <= 1'b0;
        end else if (cnt0 == 12'd0) begin
          cnt0 <= tone0_period - 12'd1;
          ph0  <= ~ph0;
        end else begin
          cnt0 <= cnt0 - 12'd1;
        end

        on1 <= tone1_period != 12'd0;
        if (tone1_period == 12'd0) begin
          cnt1 <= '0;
          ph1  <= 1'b0;
        end else if (cnt1 == 12'd0) begin
          cnt1 <= tone1_period - 12'd1;
          ph1  <= ~ph1;
        end else begin
          cnt1 <= cnt1 - 12'd1;
        end

        non <= noise_rate != 4'd0;
        if (noise_rate == 4'd0) begin
          ncnt <= '0;
        end else if (ncnt == 8'd0) begin
          ncnt <= {noise_rate, 4'h0} - 8'd1;
          lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        end else begin
          ncnt <= ncnt - 8'd1;
        end
      end
      if (pend) begin
        sample       <= sat;
        sample_valid <= 1'b1;
      end
    end
  end

endmodule
